// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar-lander flight core.
package ll_pkg;

  typedef enum logic [1:0] {
    FLY,
    LANDED,
    CRASHED
  } ll_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'h9;

endpackage

// File: rtl/ll_bcd_addsub_n.sv
// Multi-digit BCD adder/subtractor.
// op=0: result = a + b, cout = carry out.
// op=1: result = a - b (ten's complement when negative), cout = borrow out (a < b).
module ll_bcd_addsub_n
  import ll_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                op,
  output logic [4*DIGITS-1:0] result,
  output logic                cout
);

  // Ripple through the digits; subtraction adds the nine's complement plus one.
  always_comb begin
    logic       c;
    logic [4:0] s;
    bcd_digit_t bd;
    c      = op;
    s      = '0;
    bd     = '0;
    result = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bd = op ? (BCD_NINE - b[4*i +: 4]) : b[4*i +: 4];
      s  = {1'b0, a[4*i +: 4]} + {1'b0, bd} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      result[4*i +: 4] = s[3:0];
    end
    cout = op ? ~c : c;
  end

endmodule

// File: rtl/ll_flight_core.sv
// Lunar-lander flight core: BCD physics, tick divider and FLY/LANDED/CRASHED FSM.
module ll_flight_core
  import ll_pkg::*;
#(
  parameter int                DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] ALTITUDE  = 16'h4500,
  parameter logic [4*DIGITS-1:0] FUEL      = 16'h0800,
  parameter bcd_digit_t        THRUST      = 4'h5,
  parameter bcd_digit_t        GRAVITY     = 4'h5,
  parameter bcd_digit_t        MAX_THRUST  = 4'h9,
  parameter bcd_digit_t        LAND_THRUST = 4'h5,
  parameter logic [4*DIGITS-1:0] CRASH_VEL = 16'h0030,
  parameter int                TICK_DIV    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pause,
  input  logic                thrust_wr,
  input  logic [3:0]          thrust_in,
  output logic [4*DIGITS-1:0] alt,
  output logic [4*DIGITS-1:0] vel_mag,
  output logic                vel_neg,
  output logic [4*DIGITS-1:0] fuel,
  output logic [3:0]          thrust,
  output logic                tick,
  output logic                landed,
  output logic                crashed
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  ll_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  alt_n, vel_mag_n, fuel_n;
  logic          vel_neg_n, tick_n;
  bcd_digit_t    thrust_n;

  bcd_digit_t    teff, d_mag;
  logic          d_neg;
  logic [W-1:0]  teff_w, d_w;
  logic [W-1:0]  fuel_sub, alt_res, vel_res, velr_res;
  logic          fuel_bo, alt_co, vel_co, velr_co;
  logic          wrap, touchdown, crash_cond;
  logic [W-1:0]  alt_next, vel_next;
  logic          vel_neg_next;

  // Effective thrust is limited by remaining fuel; d = teff - GRAVITY as signed magnitude.
  always_comb begin
    teff   = (fuel < W'(thrust)) ? fuel[3:0] : thrust;
    d_neg  = (teff < GRAVITY);
    d_mag  = d_neg ? (GRAVITY - teff) : (teff - GRAVITY);
    teff_w = W'(teff);
    d_w    = W'(d_mag);
  end

  ll_bcd_addsub_n #(.DIGITS(DIGITS)) u_fuel_sub (
    .a(fuel), .b(teff_w), .op(1'b1), .result(fuel_sub), .cout(fuel_bo)
  );

  ll_bcd_addsub_n #(.DIGITS(DIGITS)) u_alt_sum (
    .a(alt), .b(vel_mag), .op(vel_neg), .result(alt_res), .cout(alt_co)
  );

  ll_bcd_addsub_n #(.DIGITS(DIGITS)) u_vel_sum (
    .a(vel_mag), .b(d_w), .op(vel_neg ^ d_neg), .result(vel_res), .cout(vel_co)
  );

  ll_bcd_addsub_n #(.DIGITS(DIGITS)) u_vel_rev (
    .a(d_w), .b(vel_mag), .op(1'b1), .result(velr_res), .cout(velr_co)
  );

  // Signed-magnitude combine for velocity and altitude, with saturation and touchdown detect.
  always_comb begin
    if (vel_neg == d_neg) begin
      vel_next     = vel_co ? ALL_NINES : vel_res;
      vel_neg_next = vel_neg;
    end else if (vel_co) begin
      vel_next     = velr_res;
      vel_neg_next = d_neg;
    end else begin
      vel_next     = vel_res;
      vel_neg_next = vel_neg;
    end
    if (vel_next == '0) vel_neg_next = 1'b0;

    if (vel_neg) begin
      touchdown = alt_co || (alt_res == '0);
      alt_next  = alt_res;
    end else begin
      touchdown = !alt_co && (alt_res == '0);
      alt_next  = alt_co ? ALL_NINES : alt_res;
    end

    crash_cond = (vel_mag >= CRASH_VEL) || (teff > LAND_THRUST);
    wrap       = (cnt == CW'(TICK_DIV - 1));
  end

  // Next-state and next-register values: divider, physics update and thrust writes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tick_n    = 1'b0;
    alt_n     = alt;
    vel_mag_n = vel_mag;
    vel_neg_n = vel_neg;
    fuel_n    = fuel;
    thrust_n  = thrust;

    if (thrust_wr && (thrust_in <= BCD_NINE))
      thrust_n = (thrust_in > MAX_THRUST) ? MAX_THRUST : thrust_in;

    case (state)
      FLY: begin
        if (!pause) begin
          if (wrap) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            fuel_n = fuel_sub;
            if (touchdown) begin
              alt_n     = '0;
              vel_mag_n = '0;
              vel_neg_n = 1'b0;
              state_n   = crash_cond ? CRASHED : LANDED;
            end else begin
              alt_n     = alt_next;
              vel_mag_n = vel_next;
              vel_neg_n = vel_neg_next;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous reset to the launch conditions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FLY;
      cnt     <= '0;
      tick    <= 1'b0;
      alt     <= ALTITUDE;
      vel_mag <= '0;
      vel_neg <= 1'b0;
      fuel    <= FUEL;
      thrust  <= THRUST;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tick    <= tick_n;
      alt     <= alt_n;
      vel_mag <= vel_mag_n;
      vel_neg <= vel_neg_n;
      fuel    <= fuel_n;
      thrust  <= thrust_n;
    end
  end

  assign landed  = (state == LANDED);
  assign crashed = (state == CRASHED);

endmodule

// File: doc/ll_flight_core.md
Name: ll_flight_core

Overview:
- Parametrised successor to the lunar-lander memory/ALU/control trio, merged into one sequential core.
- Holds altitude, velocity, fuel and thrust as N-digit BCD values and advances the physics once per internal tick.
- Ticks come from a built-in clock divider, with pause support.
- Runs a flight state machine (FLY/LANDED/CRASHED) with a registered thrust-write port. Sits between the pushbutton input logic and the display unit in top.

Parameters:
DIGITS, 4, number of BCD digits per quantity; W = 4*DIGITS
ALTITUDE, 16'h4500, reset altitude (BCD, W bits)
FUEL, 16'h0800, reset fuel (BCD)
THRUST, 4'h5, reset thrust (BCD digit, 0-9)
GRAVITY, 4'h5, downward acceleration per tick (BCD digit)
MAX_THRUST, 4'h9, thrust writes above this clamp to it
LAND_THRUST, 4'h5, thrust above this at touchdown = crash
CRASH_VEL, 16'h0030, touchdown speed >= this = crash (BCD magnitude)
TICK_DIV, 1, clk cycles per physics tick (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
pause  in  1  freezes tick divider and physics while high
thrust_wr  in  1  one-cycle strobe: load thrust_in
thrust_in  in  4  requested thrust, BCD digit
alt  out  W  altitude, BCD, unsigned
vel_mag  out  W  velocity magnitude, BCD
vel_neg  out  1  1 = moving down; forced 0 when vel_mag==0
fuel  out  W  fuel, BCD
thrust  out  4  current commanded thrust, BCD
tick  out  1  one-cycle pulse on each physics update
landed  out  1  state==LANDED
crashed  out  1  state==CRASHED

Behaviour:
- Reset (async, any time, including mid-tick):
  - alt=ALTITUDE, vel_mag=0, vel_neg=0, fuel=FUEL, thrust=THRUST.
  - Divider count=0, tick=0, state=FLY.
- Divider:
  - Counts 0..TICK_DIV-1 while !pause and state==FLY; holds while pause=1.
  - Wrap cycle: registered tick=1 for one cycle, and the physics registers update on that same edge.
  - TICK_DIV=1 means a tick every cycle.
- Thrust write:
  - thrust_in > 9 (non-BCD) is ignored.
  - Otherwise thrust <= min(thrust_in, MAX_THRUST) on the next edge.
  - Accepted in any state.
  - A write coinciding with a tick edge: that tick uses the old thrust; the new value applies from the next tick.
- Physics per tick (state FLY only), all BCD arithmetic:
  - teff = min(thrust, fuel); equals 0 when fuel==0.
  - alt_sum = alt + signed vel (current velocity, before update).
  - vel_n = vel + teff - GRAVITY (signed-magnitude; zero result has vel_neg=0).
  - fuel_n = fuel - teff (never negative by construction).
  - Velocity magnitude saturates at all-9s.
  - Upward alt_sum saturates at all-9s.
- Touchdown: alt_sum <= 0 (downward vel_mag >= alt, including exactly 0).
  - alt, vel_mag and vel_neg go to 0; fuel=fuel_n.
  - Crash condition: vel_mag (pre-update) >= CRASH_VEL, or teff > LAND_THRUST.
    - Crash condition true: state -> CRASHED.
    - Otherwise: state -> LANDED.
- LANDED / CRASHED:
  - Terminal; all quantities hold and tick stays 0.
  - Only rst exits.
- Pause in LANDED/CRASHED has no effect.

Decomposition:
- Package ll_pkg:
  - typedef enum {FLY, LANDED, CRASHED} ll_state_t.
  - typedef logic [3:0] bcd_digit_t.
  - Constant BCD_NINE.
- Sub-module ll_bcd_addsub_n (parameter DIGITS):
  - Inputs: a, b, op.
  - Outputs: DIGITS-digit BCD sum/difference, carry/borrow out.
  - Signed-magnitude combine logic lives in the core and reuses this adder (nine's-complement subtract, borrow out selects sign).

Test Plan (DIGITS=4, TICK_DIV=1 unless noted):
1. Reset, no writes -> alt=4500, vel=0, fuel=0800, thrust=5. After 1 tick: alt=4500, vel=0, fuel=0795, tick pulsed once.
2. thrust_wr thrust_in=0, then 3 ticks -> vel -5/-10/-15, alt 4500/4495/4485, fuel constant.
3. FUEL=0003, thrust=5:
   - tick1: teff=3, fuel=0000, vel -2.
   - tick2: teff=0, vel -7, fuel stays 0.
4. ALTITUDE=0020, thrust write 3:
   - alt 20/18/14/8, vel -2/-4/-6/-8.
   - Tick5 (alt_sum=0) -> landed=1, alt=0, vel=0.
   - Further cycles: no tick, values frozen.
5. ALTITUDE=0100, thrust 0:
   - alt 100/95/85/70/50/25, vel reaching -30.
   - Tick7 -> crashed=1, landed=0.
   - Repeat with LAND_THRUST violation (thrust 7, slow descent) -> crashed=1.
6. Edge cases:
   - thrust_in=4'hA -> thrust unchanged.
   - thrust_in=9 with MAX_THRUST=7 -> thrust=7.
   - TICK_DIV=4 with pause held 3 cycles -> tick period stretches by 3.
   - rst asserted mid-flight between edges -> outputs revert to reset values immediately, state FLY.
